parser_wait_segs: RTL and testbench
===================================

PARSER_WAIT_SEGS -- requirements
Module: parser_wait_segs

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256: width of one stream beat.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128: width of the stream metadata.
REQ-003 Parameter C_NUM_SEGS, default 16: maximum number of header beats captured per packet.
REQ-004 Parameter C_VLANID_WIDTH, default 12: width of the VLAN ID.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- axis_clk, in, 1: clock.
- areset, in, 1: synchronous active-high reset.
- s_axis_tdata, in, C_AXIS_DATA_WIDTH: input beat.
- s_axis_tuser, in, C_AXIS_TUSER_WIDTH: metadata, meaningful on the first beat only.
- s_axis_tvalid, in, 1: beat valid.
- s_axis_tlast, in, 1: last beat of the packet.
- s_axis_tready, out, 1: block can accept a beat.
- tdata_segs, out, C_NUM_SEGS*C_AXIS_DATA_WIDTH: captured header beats.
- tuser_1st, out, C_AXIS_TUSER_WIDTH: tuser of the first beat.
- segs_len, out, 5: number of beats captured (1..C_NUM_SEGS).
- segs_valid, out, 1: segment bundle valid.
- segs_ready, in, 1: downstream parser accepts the bundle.
- vlan_id, out, C_VLANID_WIDTH: VLAN ID from the first beat; used as the parse-action RAM read address.
- vlan_id_valid, out, 1: one-cycle strobe qualifying vlan_id.

Function
REQ-007 A beat SHALL transfer only on a cycle where s_axis_tvalid and s_axis_tready are both high.
REQ-008 The states SHALL be IDLE, COLLECT, DRAIN and HOLD.
REQ-009 s_axis_tready SHALL be 1 in IDLE, COLLECT and DRAIN, and 0 in HOLD.
REQ-010 In IDLE, a transfer SHALL perform all of the following:
- store the beat in segment 0;
- capture s_axis_tuser into tuser_1st;
- latch s_axis_tdata[116+:12] into vlan_id;
- set the beat count to 1.
REQ-011 vlan_id_valid SHALL pulse high for exactly the one cycle after a first-beat transfer.
REQ-012 Beat k of a packet (0-based, k < C_NUM_SEGS) SHALL be stored at tdata_segs[k*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH].
REQ-013 Segments not written for the current packet SHALL read as zero.
REQ-014 Byte order of stored beats SHALL be unchanged.
REQ-015 Transitions out of IDLE on a first-beat transfer:
- tlast=1 -> HOLD (single-beat packet);
- tlast=0 and C_NUM_SEGS=1 -> DRAIN;
- otherwise -> COLLECT.
REQ-016 Transitions out of COLLECT on each transfer:
- tlast=1 -> HOLD;
- the C_NUM_SEGS-th beat stored with tlast=0 -> DRAIN;
- otherwise stay in COLLECT.
REQ-017 In DRAIN, beats SHALL be accepted and discarded without modifying any output, and the transfer with tlast=1 SHALL move the state to HOLD.
REQ-018 segs_valid SHALL be high exactly while in HOLD, beginning the cycle after the transfer that caused entry to HOLD.
REQ-019 tdata_segs, tuser_1st, segs_len and vlan_id SHALL be stable while segs_valid is high.
REQ-020 segs_len SHALL equal min(beats in packet, C_NUM_SEGS).
REQ-021 A cycle in HOLD with segs_ready=1 SHALL complete the handshake and move the state to IDLE.
REQ-022 On handshake completion the segment buffer SHALL be zeroed on the same clock edge.
REQ-023 segs_valid SHALL be low, and s_axis_tready high, on the cycle after handshake completion.
REQ-024 segs_ready while not in HOLD SHALL be ignored.
REQ-025 Back-to-back packets: one bubble (the HOLD cycle) SHALL be inserted between packets at minimum, with no loss of beats.
REQ-026 s_axis_tvalid low in any state SHALL leave state, count and buffer unchanged.
REQ-027 The beat counter SHALL saturate at C_NUM_SEGS and never wrap.

Reset
REQ-028 While areset is high at a clock edge, the block SHALL enter IDLE.
REQ-029 Reset values SHALL be:
- tdata_segs, tuser_1st, segs_len and vlan_id = 0;
- segs_valid and vlan_id_valid = 0;
- s_axis_tready = 1 from the first cycle after reset deassertion.
REQ-030 Reset during COLLECT, DRAIN or HOLD SHALL discard the partial or pending bundle.
REQ-031 After reset, the next accepted beat SHALL be treated as a first beat.

Verification
REQ-032 Single-beat packet, tdata[116+:12]=12'h00A, tuser=128'h55, tlast=1 -> expected response:
- vlan_id_valid pulses with vlan_id=12'h00A;
- next cycle segs_valid=1, segs_len=1, segment 0 equals the beat, segments 1..15 = 0, tuser_1st=128'h55.
REQ-033 5-beat packet, beats 32'h1..32'h5 replicated, segs_ready held 0 for 10 cycles -> expected response:
- segs_len=5;
- segments 0..4 carry beats 1..5;
- segs_valid and data stable throughout the stall;
- s_axis_tready=0 throughout the stall.
REQ-034 20-beat packet -> expected response:
- segments 0..15 carry beats 0..15;
- beats 16..19 accepted and dropped;
- segs_len=16;
- segs_valid rises the cycle after the beat-19 transfer.
REQ-035 Two back-to-back 2-beat packets with segs_ready=1 constant -> expected response:
- two bundles delivered, each segs_len=2;
- segments 2..15 of the second bundle = 0;
- no beats lost.
REQ-036 areset pulsed high during beat 3 of a 6-beat packet, followed by a fresh 1-beat packet -> expected response:
- no segs_valid for the aborted packet;
- the fresh packet is delivered with segs_len=1 and its own tuser.

Source files
------------

// File: rtl/parser_wait_segs.sv
// Header capture stage ahead of the packet parser. Collects up to C_NUM_SEGS
// beats of each packet into a segment bundle and holds the bundle until the
// parser takes it. Any beats past C_NUM_SEGS are swallowed. The VLAN ID from
// the first beat is strobed out early so the parse-action RAM read can start
// while the rest of the header is still arriving.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for the first beat of a packet
// COLLECT | storing header beats into segments 1..C_NUM_SEGS-1
// DRAIN   | segment buffer full, discarding beats until tlast
// HOLD    | bundle presented on segs_valid, input stalled until segs_ready

module parser_wait_segs #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_SEGS         = 16,
   parameter int C_VLANID_WIDTH     = 12
) (
   input  logic                                    axis_clk,
   input  logic                                    areset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
   input  logic                                    s_axis_tvalid,
   input  logic                                    s_axis_tlast,
   output logic                                    s_axis_tready,
   output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
   output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
   output logic [4:0]                              segs_len,
   output logic                                    segs_valid,
   input  logic                                    segs_ready,
   output logic [C_VLANID_WIDTH-1:0]               vlan_id,
   output logic                                    vlan_id_valid
);

   localparam int         W            = C_AXIS_DATA_WIDTH;
   localparam logic [4:0] NUM_SEGS_L   = 5'(C_NUM_SEGS);
   localparam logic [4:0] LAST_SEG_IDX = 5'(C_NUM_SEGS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [W-1:0] seg_mem [C_NUM_SEGS];
   logic [4:0]   beat_cnt;

   logic         xfer;
   logic         store_en;
   logic         first_beat;
   logic         clear_buf;
   logic [4:0]   wr_idx;

   assign xfer     = s_axis_tvalid & s_axis_tready;
   assign segs_len = beat_cnt;

   // Next-state decode plus the handshake outputs and datapath strobes.
   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b1;
      segs_valid    = 1'b0;
      store_en      = 1'b0;
      first_beat    = 1'b0;
      clear_buf     = 1'b0;
      wr_idx        = beat_cnt;
      case (state)
         IDLE: begin
            wr_idx = 5'd0;
            if (xfer) begin
               store_en   = 1'b1;
               first_beat = 1'b1;
               if (s_axis_tlast)
                  state_nxt = HOLD;
               else if (C_NUM_SEGS == 1)
                  state_nxt = DRAIN;
               else
                  state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (xfer) begin
               store_en = 1'b1;
               if (s_axis_tlast)
                  state_nxt = HOLD;
               else if (beat_cnt == LAST_SEG_IDX)
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && s_axis_tlast)
               state_nxt = HOLD;
         end
         HOLD: begin
            s_axis_tready = 1'b0;
            segs_valid    = 1'b1;
            if (segs_ready) begin
               clear_buf = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge axis_clk) begin
      if (areset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Segment buffer, first-beat metadata and saturating beat counter.
   always_ff @(posedge axis_clk) begin
      if (areset) begin
         for (int k = 0; k < C_NUM_SEGS; k++)
            seg_mem[k] <= '0;
         tuser_1st     <= '0;
         vlan_id       <= '0;
         vlan_id_valid <= 1'b0;
         beat_cnt      <= 5'd0;
      end else begin
         vlan_id_valid <= first_beat;
         if (clear_buf) begin
            for (int k = 0; k < C_NUM_SEGS; k++)
               seg_mem[k] <= '0;
         end
         if (store_en) begin
            for (int k = 0; k < C_NUM_SEGS; k++)
               if (wr_idx == 5'(k))
                  seg_mem[k] <= s_axis_tdata;
            if (first_beat)
               beat_cnt <= 5'd1;
            else if (beat_cnt != NUM_SEGS_L)
               beat_cnt <= beat_cnt + 5'd1;
         end
         if (first_beat) begin
            tuser_1st <= s_axis_tuser;
            vlan_id   <= s_axis_tdata[116 +: C_VLANID_WIDTH];
         end
      end
   end

   // Flatten the segment array onto the bundle bus, segment 0 in the low bits.
   for (genvar g = 0; g < C_NUM_SEGS; g++) begin : g_pack
      assign tdata_segs[g*W +: W] = seg_mem[g];
   end

endmodule

// File: tb/tb_parser_wait_segs.sv
// Directed plus randomized bench for parser_wait_segs. Each packet is held as
// a queue of beats; the expected bundle is the first min(n,16) beats with the
// remaining segments zero.

module tb_parser_wait_segs;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int NS = 16;
   localparam int VW = 12;

   logic             axis_clk = 1'b0;
   logic             areset;
   logic [DW-1:0]    s_axis_tdata;
   logic [UW-1:0]    s_axis_tuser;
   logic             s_axis_tvalid;
   logic             s_axis_tlast;
   logic             s_axis_tready;
   logic [NS*DW-1:0] tdata_segs;
   logic [UW-1:0]    tuser_1st;
   logic [4:0]       segs_len;
   logic             segs_valid;
   logic             segs_ready;
   logic [VW-1:0]    vlan_id;
   logic             vlan_id_valid;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] pkt_q [$];
   logic [UW-1:0] pkt_user;

   parser_wait_segs #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(UW),
      .C_NUM_SEGS        (NS),
      .C_VLANID_WIDTH    (VW)
   ) dut (
      .axis_clk     (axis_clk),
      .areset       (areset),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .tdata_segs   (tdata_segs),
      .tuser_1st    (tuser_1st),
      .segs_len     (segs_len),
      .segs_valid   (segs_valid),
      .segs_ready   (segs_ready),
      .vlan_id      (vlan_id),
      .vlan_id_valid(vlan_id_valid)
   );

   always #5 axis_clk = ~axis_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] b;
      for (int i = 0; i < DW/32; i++)
         b[i*32 +: 32] = $urandom();
      return b;
   endfunction

   function automatic logic [UW-1:0] rand_user();
      logic [UW-1:0] u;
      for (int i = 0; i < UW/32; i++)
         u[i*32 +: 32] = $urandom();
      return u;
   endfunction

   // Expected bundle content for segment k of the packet held in pkt_q.
   function automatic logic [DW-1:0] exp_seg(input int k);
      if (k < pkt_q.size())
         return pkt_q[k];
      return '0;
   endfunction

   // Transfer one beat; returns #1 after the accepting edge with tvalid low.
   task automatic push_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                            input logic last, input bit first, input int gap);
      int t;
      repeat (gap) @(negedge axis_clk);
      @(negedge axis_clk);
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      t = 0;
      while (!s_axis_tready && t < 50) begin
         @(negedge axis_clk);
         t++;
      end
      if (t >= 50)
         chk("tready_timeout", DW'(s_axis_tready), DW'(1));
      @(posedge axis_clk);
      #1;
      s_axis_tvalid = 1'b0;
      if (first) begin
         chk("vlan_valid_pulse", DW'(vlan_id_valid), DW'(1));
         chk("vlan_id", DW'(vlan_id), DW'(d[116 +: VW]));
      end else begin
         chk("vlan_valid_low", DW'(vlan_id_valid), DW'(0));
      end
      chk("segs_valid_after_beat", DW'(segs_valid), DW'(last));
   endtask

   // Check the bundle right after the last beat, stall, then hand it off.
   task automatic deliver(input int stall, input bit keep_ready);
      int exp_len;
      exp_len = (pkt_q.size() < NS) ? pkt_q.size() : NS;
      chk("hold_tready", DW'(s_axis_tready), DW'(0));
      chk("segs_len", DW'(segs_len), DW'(exp_len));
      chk("tuser_1st", DW'(tuser_1st), DW'(pkt_user));
      for (int k = 0; k < NS; k++)
         chk($sformatf("seg%0d", k), tdata_segs[k*DW +: DW], exp_seg(k));
      if (!segs_ready) begin
         for (int c = 0; c < stall; c++) begin
            @(posedge axis_clk);
            #1;
            chk("stall_valid", DW'(segs_valid), DW'(1));
            chk("stall_tready", DW'(s_axis_tready), DW'(0));
            chk("stall_len", DW'(segs_len), DW'(exp_len));
            chk("stall_user", DW'(tuser_1st), DW'(pkt_user));
            chk("stall_vlan", DW'(vlan_id), DW'(pkt_q[0][116 +: VW]));
            for (int k = 0; k < NS; k++)
               chk($sformatf("stall_seg%0d", k), tdata_segs[k*DW +: DW], exp_seg(k));
         end
         @(negedge axis_clk);
         segs_ready = 1'b1;
      end
      @(posedge axis_clk);
      #1;
      segs_ready = keep_ready;
      chk("post_hs_valid", DW'(segs_valid), DW'(0));
      chk("post_hs_tready", DW'(s_axis_tready), DW'(1));
      for (int k = 0; k < NS; k++)
         chk($sformatf("post_hs_seg%0d", k), tdata_segs[k*DW +: DW], '0);
   endtask

   // Send every beat in pkt_q as one packet and collect the bundle.
   task automatic run_packet(input int stall, input bit ready_during, input int gapmax);
      segs_ready = ready_during;
      for (int i = 0; i < pkt_q.size(); i++)
         push_beat(pkt_q[i], (i == 0) ? pkt_user : rand_user(),
                   (i == pkt_q.size() - 1), (i == 0),
                   (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      deliver(stall, ready_during);
   endtask

   initial begin
      logic [DW-1:0] b;
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      segs_ready    = 1'b0;
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      areset = 1'b0;
      @(posedge axis_clk);
      #1;
      chk("rst_tready", DW'(s_axis_tready), DW'(1));
      chk("rst_segs_valid", DW'(segs_valid), DW'(0));
      chk("rst_vlan_valid", DW'(vlan_id_valid), DW'(0));
      chk("rst_segs_len", DW'(segs_len), DW'(0));
      chk("rst_tuser", DW'(tuser_1st), DW'(0));
      chk("rst_vlan", DW'(vlan_id), DW'(0));
      for (int k = 0; k < NS; k++)
         chk($sformatf("rst_seg%0d", k), tdata_segs[k*DW +: DW], '0);

      // single-beat packet with VLAN 0x00A
      pkt_q.delete();
      b = rand_beat();
      b[116 +: VW] = 12'h00A;
      pkt_q.push_back(b);
      pkt_user = 128'h55;
      run_packet(2, 1'b0, 0);

      // 5-beat packet with a 10-cycle downstream stall
      pkt_q.delete();
      for (int i = 1; i <= 5; i++) begin
         b = {8{32'(i)}};
         pkt_q.push_back(b);
      end
      pkt_user = rand_user();
      run_packet(10, 1'b0, 0);

      // 20-beat packet: beats 16..19 dropped
      pkt_q.delete();
      for (int i = 0; i < 20; i++)
         pkt_q.push_back(rand_beat());
      pkt_user = rand_user();
      run_packet(1, 1'b0, 0);

      // two back-to-back 2-beat packets, segs_ready held high
      for (int p = 0; p < 2; p++) begin
         pkt_q.delete();
         pkt_q.push_back(rand_beat());
         pkt_q.push_back(rand_beat());
         pkt_user = rand_user();
         run_packet(0, 1'b1, 0);
      end
      segs_ready = 1'b0;

      // reset in the middle of a 6-beat packet, then a fresh single beat
      push_beat(rand_beat(), rand_user(), 1'b0, 1'b1, 0);
      push_beat(rand_beat(), rand_user(), 1'b0, 1'b0, 0);
      @(negedge axis_clk);
      s_axis_tdata  = rand_beat();
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      areset        = 1'b1;
      @(posedge axis_clk);
      #1;
      areset        = 1'b0;
      s_axis_tvalid = 1'b0;
      chk("abort_tready", DW'(s_axis_tready), DW'(1));
      chk("abort_len", DW'(segs_len), DW'(0));
      chk("abort_tuser", DW'(tuser_1st), DW'(0));
      chk("abort_seg0", tdata_segs[0 +: DW], '0);
      chk("abort_seg1", tdata_segs[DW +: DW], '0);
      for (int c = 0; c < 3; c++) begin
         @(posedge axis_clk);
         #1;
         chk("abort_no_valid", DW'(segs_valid), DW'(0));
      end
      pkt_q.delete();
      pkt_q.push_back(rand_beat());
      pkt_user = rand_user();
      run_packet(0, 1'b0, 0);

      // randomized packets with idle gaps and early segs_ready
      for (int p = 0; p < 12; p++) begin
         int n;
         n = $urandom_range(1, 20);
         pkt_q.delete();
         for (int i = 0; i < n; i++)
            pkt_q.push_back(rand_beat());
         pkt_user = rand_user();
         run_packet($urandom_range(0, 3), 1'($urandom_range(0, 1)), 2);
         segs_ready = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
